// File: rtl/clock_failover_controller_pkg.sv
// rtl/clock_failover_controller_pkg.sv - shared FSM type and width helpers for the clock failover controller
// Purpose: state encoding and counter-width helpers used by the top level and the per-channel detector.
// Ports: none (package).
package clock_failover_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    GUARD  = 2'd2
  } state_e;

  // Window counter spans 0..window-1.
  function automatic int win_cnt_w(input int window);
    return (window > 1) ? $clog2(window) : 1;
  endfunction

  // Edge counter saturates at min_edges, so it needs min_edges+1 codes.
  function automatic int edge_cnt_w(input int min_edges);
    return (min_edges > 0) ? $clog2(min_edges + 1) : 1;
  endfunction

  // Streak saturates at holdoff.
  function automatic int streak_w(input int holdoff);
    return (holdoff > 0) ? $clog2(holdoff + 1) : 1;
  endfunction

  function automatic int idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Guard counter counts 0..guard_cycles-1.
  function automatic int guard_cnt_w(input int guard_cycles);
    return $clog2(guard_cycles + 1);
  endfunction

endpackage

// File: rtl/clock_activity_detector.sv
// rtl/clock_activity_detector.sv - per-channel activity qualifier for one monitored clock
// Purpose: synchronise one candidate clock, count its rising edges per window and
//          qualify it alive after HOLDOFF consecutive good windows.
// Ports:
//   clock           in  reference clock
//   resetn          in  asynchronous active-low reset
//   monitored_clock in  candidate clock, treated as asynchronous data
//   window_end      in  one-cycle strobe on the last cycle of each window
//   alive           out registered alive flag
module clock_activity_detector
  import clock_failover_controller_pkg::*;
#(
  parameter int STAGES    = 2,
  parameter int MIN_EDGES = 4,
  parameter int HOLDOFF   = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic monitored_clock,
  input  logic window_end,
  output logic alive
);

  localparam int EW = edge_cnt_w(MIN_EDGES);
  localparam int SW = streak_w(HOLDOFF);
  localparam logic [EW-1:0] EDGE_SAT   = EW'(MIN_EDGES);
  localparam logic [SW-1:0] STREAK_SAT = SW'(HOLDOFF);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              alive_q, alive_d;
  logic              rise;

  always_comb begin
    sync_d     = {sync_q[STAGES-2:0], monitored_clock};
    prev_d     = sync_q[STAGES-1];
    rise       = sync_q[STAGES-1] & ~prev_q;
    edge_cnt_d = edge_cnt_q;
    streak_d   = streak_q;
    alive_d    = alive_q;
    if (window_end) begin
      // An edge landing on the window-end cycle itself is dropped: the counter restarts at 0.
      edge_cnt_d = '0;
      if (edge_cnt_q >= EDGE_SAT) begin
        if (streak_q != STREAK_SAT) begin
          streak_d = streak_q + 1'b1;
        end
        alive_d = (streak_d == STREAK_SAT);
      end else begin
        // One bad window is enough to drop the channel.
        streak_d = '0;
        alive_d  = 1'b0;
      end
    end else if (rise && (edge_cnt_q != EDGE_SAT)) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_cnt_q <= '0;
      streak_q   <= '0;
      alive_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      edge_cnt_q <= edge_cnt_d;
      streak_q   <= streak_d;
      alive_q    <= alive_d;
    end
  end

  assign alive = alive_q;

endmodule

// File: rtl/clock_failover_controller.sv
// rtl/clock_failover_controller.sv - prioritised N-input clock failover supervisor
// Purpose: qualifies CHANNELS candidate clocks and drives the one-hot select of a
//          glitch-free clock multiplexer, with a guard gap on every switch.
// Build option: CLOCK_FAILOVER_CONTROLLER_REVERTIVE_EN selects revertive policy
//               (return to a higher-priority clock as soon as it is alive).
// Ports:
//   clock            in  reference clock
//   resetn           in  asynchronous active-low reset
//   monitored_clocks in  candidate clocks, sampled as asynchronous data
//   channel_enable   in  per-channel qualification mask
//   clocks_alive     out registered per-channel alive status (not gated by enable)
//   selection        out one-hot mux select, zero when nothing is selected
//   selection_index  out binary index of the selection, holds while not valid
//   selection_valid  out selection is non-zero
//   switch_event     out one-cycle pulse on each entry into LOCKED
module clock_failover_controller
  import clock_failover_controller_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int STAGES       = 2,
  parameter int WINDOW       = 64,
  parameter int MIN_EDGES    = 4,
  parameter int HOLDOFF      = 2,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [CHANNELS-1:0]         monitored_clocks,
  input  logic [CHANNELS-1:0]         channel_enable,
  output logic [CHANNELS-1:0]         clocks_alive,
  output logic [CHANNELS-1:0]         selection,
  output logic [$clog2(CHANNELS)-1:0] selection_index,
  output logic                        selection_valid,
  output logic                        switch_event
);

  localparam int WW = win_cnt_w(WINDOW);
  localparam int IW = idx_w(CHANNELS);
  localparam int GW = guard_cnt_w(GUARD_CYCLES);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  logic [WW-1:0]       win_q, win_d;
  logic                window_end;
  logic [CHANNELS-1:0] alive;
  logic [CHANNELS-1:0] eff_alive;
  logic                cand_valid;
  logic [IW-1:0]       cand_idx;
  state_e              state_q, state_d;
  logic [IW-1:0]       sel_idx_q, sel_idx_d;
  logic [GW-1:0]       guard_q, guard_d;
  logic                event_q, event_d;
  logic                leave_locked;

  always_comb begin
    window_end = (win_q == WIN_LAST);
    win_d      = window_end ? '0 : win_q + 1'b1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    clock_activity_detector #(
      .STAGES   (STAGES),
      .MIN_EDGES(MIN_EDGES),
      .HOLDOFF  (HOLDOFF)
    ) u_detector (
      .clock          (clock),
      .resetn         (resetn),
      .monitored_clock(monitored_clocks[c]),
      .window_end     (window_end),
      .alive          (alive[c])
    );
  end

  // The enable mask gates every cycle, so dropping it acts like an immediate death.
  always_comb begin
    eff_alive  = alive & channel_enable;
    cand_valid = |eff_alive;
    cand_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (eff_alive[i]) begin
        cand_idx = IW'(i);
      end
    end
  end

  always_comb begin
`ifdef CLOCK_FAILOVER_CONTROLLER_REVERTIVE_EN
    leave_locked = !eff_alive[sel_idx_q] || (cand_valid && (cand_idx < sel_idx_q));
`else
    leave_locked = !eff_alive[sel_idx_q];
`endif
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    guard_d   = guard_q;
    event_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_valid) begin
          state_d   = LOCKED;
          sel_idx_d = cand_idx;
          event_d   = 1'b1;
        end
      end
      LOCKED: begin
        // Every switch goes through GUARD, even when a replacement is already alive.
        if (leave_locked) begin
          state_d = GUARD;
          guard_d = '0;
        end
      end
      GUARD: begin
        if (guard_q == GUARD_LAST) begin
          if (cand_valid) begin
            state_d   = LOCKED;
            sel_idx_d = cand_idx;
            event_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      win_q     <= '0;
      state_q   <= IDLE;
      sel_idx_q <= '0;
      guard_q   <= '0;
      event_q   <= 1'b0;
    end else begin
      win_q     <= win_d;
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
      guard_q   <= guard_d;
      event_q   <= event_d;
    end
  end

  always_comb begin
    selection = '0;
    if (state_q == LOCKED) begin
      selection[sel_idx_q] = 1'b1;
    end
  end

  assign selection_valid = (state_q == LOCKED);
  assign selection_index = sel_idx_q;
  assign switch_event    = event_q;
  assign clocks_alive    = alive;

endmodule

// File: tb/tb_clock_failover_controller.sv
// tb/tb_clock_failover_controller.sv - self-checking bench for clock_failover_controller
module tb_clock_failover_controller;

  localparam int CH = 4;
  localparam int ST = 2;
  localparam int W  = 64;
  localparam int ME = 4;
  localparam int HO = 2;
  localparam int GC = 4;
`ifdef CLOCK_FAILOVER_CONTROLLER_REVERTIVE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic          clock;
  logic          resetn;
  logic [CH-1:0] monitored_clocks;
  logic [CH-1:0] channel_enable;
  logic [CH-1:0] clocks_alive;
  logic [CH-1:0] selection;
  logic [1:0]    selection_index;
  logic          selection_valid;
  logic          switch_event;

  clock_failover_controller dut (
    .clock           (clock),
    .resetn          (resetn),
    .monitored_clocks(monitored_clocks),
    .channel_enable  (channel_enable),
    .clocks_alive    (clocks_alive),
    .selection       (selection),
    .selection_index (selection_index),
    .selection_valid (selection_valid),
    .switch_event    (switch_event)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Stimulus: each channel is a square wave with a period in reference cycles (0 = stopped).
  int            per[CH];
  int            ph[CH];
  logic [CH-1:0] en_r;

  // Reference model state: cycle number since reset, recent samples, per-window edge tallies.
  int            n;
  logic [CH-1:0] hist[$];
  int            cnt_m[CH];
  int            run_m[CH];
  logic [CH-1:0] alive_m;
  int            mode_m;     // 0 none, 1 locked, 2 guard
  int            sel_m;
  int            gend_m;
  logic          ev_m;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%h want=%h", nm, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    hist.delete();
    for (int c = 0; c < CH; c++) begin
      cnt_m[c] = 0;
      run_m[c] = 0;
    end
    alive_m = '0;
    mode_m  = 0;
    sel_m   = 0;
    gend_m  = 0;
    ev_m    = 1'b0;
  endtask

  function automatic logic [CH-1:0] samp(input int k);
    return (k < hist.size()) ? hist[k] : '0;
  endfunction

  task automatic model_edge(input logic [CH-1:0] mon, input logic [CH-1:0] en);
    logic [CH-1:0] eff, s_new, s_old;
    int cand;
    hist.push_front(mon);
    if (hist.size() > ST + 2) void'(hist.pop_back());
    eff  = alive_m & en;
    cand = -1;
    for (int c = CH - 1; c >= 0; c--) if (eff[c]) cand = c;
    ev_m = 1'b0;
    if (mode_m == 0) begin
      if (cand >= 0) begin mode_m = 1; sel_m = cand; ev_m = 1'b1; end
    end else if (mode_m == 1) begin
      if (!eff[sel_m] || (REV && cand >= 0 && cand < sel_m)) begin
        mode_m = 2;
        gend_m = n + GC;
      end
    end else if (n == gend_m) begin
      if (cand >= 0) begin mode_m = 1; sel_m = cand; ev_m = 1'b1; end
      else mode_m = 0;
    end
    // A rising edge sampled at cycle k reaches the counter at cycle k+ST.
    s_new = samp(ST);
    s_old = samp(ST + 1);
    for (int c = 0; c < CH; c++) begin
      if (n % W == 0) begin
        if (cnt_m[c] >= ME) begin
          run_m[c]   = (run_m[c] + 1 > HO) ? HO : run_m[c] + 1;
          alive_m[c] = (run_m[c] >= HO);
        end else begin
          run_m[c]   = 0;
          alive_m[c] = 1'b0;
        end
        cnt_m[c] = 0;
      end else if (s_new[c] && !s_old[c]) begin
        cnt_m[c]++;
      end
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({clocks_alive, selection, selection_index, selection_valid, switch_event});
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [CH-1:0] oh;
    logic [1:0]    si;
    oh = '0;
    si = 2'(sel_m);
    if (mode_m == 1) oh[sel_m] = 1'b1;
    return 32'({alive_m, oh, si, (mode_m == 1), ev_m});
  endfunction

  task automatic step();
    logic [CH-1:0] mon;
    @(negedge clock);
    for (int c = 0; c < CH; c++) begin
      if (per[c] == 0) mon[c] = 1'b0;
      else begin
        ph[c]  = (ph[c] + 1) % per[c];
        mon[c] = (ph[c] < per[c] / 2);
      end
    end
    monitored_clocks = mon;
    channel_enable   = en_r;
    @(posedge clock);
    if (resetn) begin
      n++;
      model_edge(monitored_clocks, channel_enable);
    end
    #1;
    check("cycle", dut_vec(), exp_vec());
  endtask

  task automatic align();
    int k;
    k = 0;
    while ((n % W) != 0 && k < W) begin step(); k++; end
  endtask

  typedef struct {
    string           nm;
    logic [3:0][7:0] per;
    logic [3:0]      en;
    int              cyc;
    logic [3:0]      ex_alive;
    logic [3:0]      ex_sel;
  } vec_t;

  function automatic vec_t mk(input string nm, input int p0, input int p1, input int p2, input int p3,
                              input logic [3:0] en, input int cyc, input logic [3:0] ea,
                              input logic [3:0] es);
    vec_t v;
    v.nm = nm;
    v.per[0] = 8'(p0); v.per[1] = 8'(p1); v.per[2] = 8'(p2); v.per[3] = 8'(p3);
    v.en = en; v.cyc = cyc; v.ex_alive = ea; v.ex_sel = es;
    return v;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog n=%0d got=running want=finished", n);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    int   k;
    int   zc;
    int   picks[9] = '{0, 4, 6, 8, 12, 14, 16, 18, 40};

    tbl.push_back(mk("stopped",     0, 0, 0, 0,  4'b1111, 640, 4'b0000, 4'b0000));
    tbl.push_back(mk("ch2_up",      0, 0, 8, 0,  4'b1111, 192, 4'b0100, 4'b0100));
    tbl.push_back(mk("ch0_up",      8, 0, 8, 0,  4'b1111, 192, 4'b0101, REV ? 4'b0001 : 4'b0100));
    tbl.push_back(mk("ch3_up",      8, 0, 8, 8,  4'b1111, 192, 4'b1101, REV ? 4'b0001 : 4'b0100));
    tbl.push_back(mk("ch2_stop",    8, 0, 0, 8,  4'b1110, 192, 4'b1001, 4'b1000));
    tbl.push_back(mk("ch3_slow",    8, 0, 0, 40, 4'b1110, 192, 4'b0001, 4'b0000));
    tbl.push_back(mk("ch0_en",      8, 0, 0, 40, 4'b1111, 16,  4'b0001, 4'b0001));
    tbl.push_back(mk("ch0_dis",     8, 0, 0, 40, 4'b1110, 16,  4'b0001, 4'b0000));
    tbl.push_back(mk("ch0_reen",    8, 0, 0, 40, 4'b1111, 16,  4'b0001, 4'b0001));

    resetn = 1'b0;
    monitored_clocks = '0;
    channel_enable = '1;
    en_r = '1;
    for (int c = 0; c < CH; c++) begin per[c] = 0; ph[c] = 0; end
    model_reset();
    #23;
    check("reset_state", dut_vec(), 32'd0);
    @(posedge clock);
    #2 resetn = 1'b1;

    foreach (tbl[i]) begin
      for (int c = 0; c < CH; c++) per[c] = int'(tbl[i].per[c]);
      en_r = tbl[i].en;
      repeat (tbl[i].cyc) step();
      check({tbl[i].nm, "_alive"}, 32'(clocks_alive), 32'(tbl[i].ex_alive));
      check({tbl[i].nm, "_sel"}, 32'(selection), 32'(tbl[i].ex_sel));
    end

    // Failover 0 -> 3 with the stop aligned to a window boundary.
    per[3] = 8;
    repeat (192) step();
    align();
    per[0] = 0;
    k = 0;
    do begin step(); k++; end while (selection != 0 && k < 80);
    check("drop_latency", 32'(k <= W + 1), 32'd1);
    zc = 1;
    k = 0;
    while (selection == 0 && k < 20) begin
      step();
      if (selection == 0) zc++;
      k++;
    end
    check("guard_len", 32'(zc), 32'(GC));
    check("new_sel", 32'({selection, switch_event}), 32'({4'b1000, 1'b1}));

    // Asynchronous reset in the middle of a guard interval, then requalification.
    align();
    per[3] = 0;
    per[2] = 8;
    k = 0;
    do begin step(); k++; end while (selection != 0 && k < 80);
    check("guard_entered", 32'(selection), 32'd0);
    repeat (2) step();
    #1 resetn = 1'b0;
    #1 check("async_reset", dut_vec(), 32'd0);
    model_reset();
    repeat (3) step();
    #1 resetn = 1'b1;
    k = 0;
    repeat (2 * W - 1) begin step(); if (clocks_alive != 0) k++; end
    check("requal_early", 32'(k), 32'd0);
    step();
    check("requal_ch2", 32'(clocks_alive), 32'b0100);

    // Randomised segments checked cycle by cycle against the model.
    for (int s = 0; s < 40; s++) begin
      for (int c = 0; c < CH; c++) begin
        per[c]  = picks[$urandom_range(0, 8)];
        en_r[c] = ($urandom_range(0, 4) != 0);
      end
      repeat ($urandom_range(40, 300)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_failover_controller.md
# clock_failover_controller

Reference-clock-domain supervisor that monitors the activity of CHANNELS asynchronous candidate clocks and picks which one a downstream glitch-free clock multiplexer should forward. It generalises two-input switchover to N prioritised inputs with windowed activity qualification, hysteresis, a guard interval on every switch, and an optional revertive policy. It sits beside the clock multiplexer and drives that multiplexer's one-hot select.

## Interface
- CHANNELS, 4: number of monitored clocks, ≥2; index 0 has the highest priority.
- STAGES, 2: synchroniser depth for each monitored clock, ≥2.
- WINDOW, 64: length of the measurement window in reference cycles, ≥4.
- MIN_EDGES, 4: minimum rising edges per window for a window to count as good, ≥1.
- HOLDOFF, 2: consecutive good windows needed to declare a channel alive, ≥1.
- GUARD_CYCLES, 4: cycles with no selection between releasing one clock and selecting the next, ≥1.
- clock  input  1  reference clock; must be faster than 2× the fastest monitored clock.
- resetn  input  1  asynchronous active-low reset.
- monitored_clocks  input  CHANNELS  candidate clocks, sampled as asynchronous data.
- channel_enable  input  CHANNELS  per-channel qualification mask, synchronous to clock.
- clocks_alive  output  CHANNELS  per-channel alive status, registered.
- selection  output  CHANNELS  one-hot select to the multiplexer; all zero when nothing is selected.
- selection_index  output  $clog2(CHANNELS)  binary index of the selected channel; holds its last value while selection_valid is 0.
- selection_valid  output  1  high when selection is non-zero.
- switch_event  output  1  one-cycle pulse on each entry into LOCKED.

## Operation
- Per channel, in order: STAGES-flop synchroniser, then a rising-edge detector, then a saturating edge counter of width $clog2(MIN_EDGES+1).
- A shared window counter runs from 0 to WINDOW-1 and wraps. At the end of a window (count = WINDOW-1), each channel is evaluated:
  - Edge count ≥ MIN_EDGES: the streak increments, saturating at HOLDOFF. alive is set when the streak reaches HOLDOFF.
  - Otherwise: the streak and alive clear immediately. A single bad window therefore kills a channel.
  - Edge counters then restart at 0.
- Effective alive = alive AND channel_enable. The enable gate applies every cycle, not only at window ends.
- Candidate = lowest-index effectively-alive channel.
- FSM:
  - IDLE: no selection. If any channel is effectively alive, go to LOCKED on the candidate and pulse switch_event.
  - LOCKED: the selected channel stays selected.
    - If it stops being effectively alive, go to GUARD.
    - With revertive mode, a higher-priority candidate also triggers GUARD.
  - GUARD: selection is all zero and the guard counter runs GUARD_CYCLES cycles. On expiry, re-evaluate the candidate at that cycle: go to LOCKED on it (pulse switch_event), or to IDLE if none exists.
- The state enum is IDLE, LOCKED, GUARD.
- Simultaneous events: if the selected channel dies in the same window as another becomes alive, the controller still passes through GUARD. No direct LOCKED-to-LOCKED transition exists.
- If channel_enable drops for the selected channel, behaviour is the same as the channel dying.

## Timing
- Reset values:
  - Outputs: selection, selection_index, selection_valid, clocks_alive, switch_event are all 0.
  - Internal: window counter, all counters and streaks are 0; FSM is in IDLE.
- Edge-detect latency is STAGES+1 cycles from a monitored rising edge to the counter increment.
- Qualification takes at least HOLDOFF full windows from first activity. Worst case is (HOLDOFF+1)·WINDOW cycles.
- clocks_alive updates on the clock edge that ends the window.
- The FSM reacts one cycle after clocks_alive changes. selection and switch_event are registered with the state.
- Failover latency: at most WINDOW+1 cycles to leave LOCKED, then GUARD_CYCLES of zero selection, then the new selection.
- Mid-operation reset returns every output to its reset value asynchronously. Qualification restarts from zero windows.

## Configuration
- CLOCK_FAILOVER_CONTROLLER_REVERTIVE_EN defined: LOCKED exits to GUARD whenever a lower-index channel becomes effectively alive, so the controller returns to the preferred clock.
- Macro absent: non-revertive. LOCKED is left only when the selected channel dies or is disabled.

## Structure
- Package clock_failover_controller_pkg holds:
  - the state enum typedef (IDLE, LOCKED, GUARD);
  - width localparam helper functions: window counter, edge counter, streak and index widths.
- Sub-module clock_activity_detector, instantiated once per channel. It contains the synchroniser, edge detector, edge counter, streak counter and alive flop, and takes the window-end strobe as input.
- The top level holds the window counter, priority encoder, FSM and guard counter.

## Test plan
Setup for all scenarios: reference clock period 10 ns, default parameters, monitored clock period 80 ns, which gives 8 edges per window.
- All clocks stopped, reset released → clocks_alive=0, selection=0, selection_valid=0 for 10 windows.
- Start channel 2 only → clocks_alive[2]=1 after 2 to 3 windows, selection=4'b0100 and switch_event pulses once. selection is never non-one-hot.
- With channel 2 locked, start channel 0:
  - Non-revertive: stays on 2.
  - Revertive: 4 cycles of selection=0, then 4'b0001.
- Stop channel 2 while channel 3 is alive → selection=0 within 65 cycles, exactly 4 guard cycles, then 4'b1000 with switch_event pulsing.
- Monitored period 400 ns (≤2 edges per window) → the channel never becomes alive. Toggle channel_enable[selected]=0 → selection clears the next cycle, then GUARD.
- Assert resetn low mid-GUARD → all outputs 0 immediately. After release, requalification takes ≥2 windows.
